// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational candidate through all input patterns, builds its truth table and
// scores it against a target. Define SWEEP_GRAY_EN to walk the patterns in Gray-code order.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   target,
  input  logic                 e_in,
  output logic [N_IN-1:0]      pat_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 match
);

  localparam int unsigned TW = 1 << N_IN;
  localparam int unsigned CW = N_IN + 1;

  typedef enum logic [1:0] {StIdle, StHold, StSample, StFin} state_e;

  localparam logic [3:0]      SettleLd = 4'(SETTLE);
  localparam logic [N_IN-1:0] IdxLast  = '1;
  // First state of every pattern slot: skip HOLD entirely when no settling is requested.
  localparam state_e          StSlot   = (SETTLE > 0) ? StHold : StSample;

  function automatic logic [N_IN-1:0] pattern_of(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   target_q, target_d;
  logic [N_IN-1:0] pat_q, pat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   tt_q, tt_d;
  logic [CW-1:0]   mm_q, mm_d;
  logic            match_q, match_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pat_d    = pat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tt_d     = tt_q;
    mm_d     = mm_q;
    match_d  = match_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d = target;
          tt_d     = '0;
          mm_d     = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          pat_d    = pattern_of('0);
          cnt_d    = SettleLd;
          busy_d   = 1'b1;
          state_d  = StSlot;
        end
      end

      StHold: begin
        if (abort) begin
          busy_d  = 1'b0;
          match_d = 1'b0;
          pat_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StSample;
          end
        end
      end

      StSample: begin
        // abort wins over the sample of the current pattern
        if (abort) begin
          busy_d  = 1'b0;
          match_d = 1'b0;
          pat_d   = '0;
          state_d = StIdle;
        end else begin
          tt_d[pat_q] = e_in;
          if (e_in != target_q[pat_q]) begin
            mm_d = mm_q + 1'b1;
          end
          if (idx_q == IdxLast) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 1'b1;
            pat_d   = pattern_of(idx_q + 1'b1);
            cnt_d   = SettleLd;
            state_d = StSlot;
          end
        end
      end

      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        match_d = (mm_q == '0);
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      pat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tt_q     <= '0;
      mm_q     <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pat_q    <= pat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tt_q     <= tt_d;
      mm_q     <= mm_d;
      match_q  <= match_d;
    end
  end

  assign pat_out      = pat_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth_table  = tt_q;
  assign mismatch_cnt = mm_q;
  assign match        = match_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/response stage wrapped around one 4-input combinational candidate circuit (inputs a,b,c,d; output e).
- Drives the candidate's inputs through every input pattern and samples e once per pattern.
- Assembles the measured truth table and scores it against a target table, producing a mismatch count for the fitness evaluator downstream.

Parameters:
- N_IN, 4, number of candidate inputs; table width TW = 2**N_IN; count width CW = N_IN+1.
- SETTLE, 1, extra cycles each pattern is held before e is sampled (range 0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; accepted only in IDLE.
- abort  in  1  synchronous cancel of a running sweep.
- target  in  TW  expected truth table; bit k = expected e for pattern k. Captured on start acceptance.
- e_in  in  1  candidate output e.
- pat_out  out  N_IN  candidate inputs; bit N_IN-1 = a (MSB) ... bit 0 = d.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- truth_table  out  TW  measured table; bit k = sampled e for pattern k.
- mismatch_cnt  out  CW  number of bits where truth_table != target.
- match  out  1  high when mismatch_cnt == 0. Valid from the done pulse.

Behaviour:
- Reset values:
  - pat_out = 0, busy = 0, done = 0, truth_table = 0, mismatch_cnt = 0, match = 0.
  - FSM in IDLE; internal index and settle counter = 0.
- FSM states: IDLE, HOLD, SAMPLE, FIN.
- IDLE:
  - start=1 -> latch target, clear truth_table and mismatch_cnt, clear match, idx = 0, pat_out = pattern(0), load settle counter with SETTLE, busy = 1.
  - Next state is HOLD if SETTLE > 0, else SAMPLE.
- HOLD: decrement the settle counter each cycle; when it reaches 1, go to SAMPLE. pat_out is stable throughout.
- SAMPLE:
  - Write e_in into truth_table[pattern(idx)].
  - If e_in != latched target[pattern(idx)], increment mismatch_cnt.
  - If idx == TW-1, go to FIN. Otherwise idx++, update pat_out, reload the settle counter, and go to HOLD or SAMPLE as above.
- FIN: done = 1 for exactly this cycle; busy = 0; match = (mismatch_cnt == 0); return to IDLE.
- Each pattern is driven for SETTLE+1 cycles and sampled on the last of them.
- Latency: done asserts exactly TW*(SETTLE+1)+1 cycles after the start-accept edge (33 cycles for defaults).
- Results (truth_table, mismatch_cnt, match) hold until the next accepted start.
- pat_out holds the last pattern after FIN.
- mismatch_cnt cannot overflow (max TW fits in CW).
- start while busy, or during FIN: ignored; no restart and no effect on the latched target.
- abort:
  - Applies in HOLD or SAMPLE. Go to IDLE next cycle; busy = 0; no done pulse; match = 0.
  - truth_table and mismatch_cnt keep their partial values; pat_out = 0.
  - abort has priority over a coincident SAMPLE write. abort in IDLE has no effect.
  - abort and start high together in IDLE: start is accepted.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous); no done pulse after release.
- target changes after acceptance have no effect until the next start.
- pattern(idx) = idx by default (binary order).

Optional Feature:
- Macro SWEEP_GRAY_EN.
- Defined:
  - pattern(idx) = idx ^ (idx >> 1), so consecutive patterns differ in one input bit (reduces glitch-induced mis-samples).
  - truth_table and target remain indexed by pattern value, not idx, so final results are identical to binary order.
- Undefined: pattern(idx) = idx; no Gray logic is synthesized.

Test Plan:
- Candidate e = a&b&d, target = 16'hA000, SETTLE=1, pulse start:
  - pat_out steps 0..15, two cycles each.
  - done at cycle 33 with truth_table = 16'hA000, mismatch_cnt = 0, match = 1.
- Same candidate, target = 16'hFFFF:
  - truth_table = 16'hA000, mismatch_cnt = 14, match = 0.
  - Then target = 16'h0000 -> mismatch_cnt = 2.
- Pulse start at cycle 5 of a running sweep:
  - Ignored; single done at cycle 33.
  - Results equal those computed from the target captured at the first start.
- Assert abort while pat_out = 4'd6:
  - busy = 0 next cycle; no done; pat_out = 0; match = 0.
  - truth_table bits 0..5 hold sampled values; bit 6 is not written.
- Drop rst_n mid-sweep:
  - All outputs = 0 asynchronously.
  - After release, a fresh start completes normally with correct results.
- SWEEP_GRAY_EN defined, SETTLE=0:
  - pat_out sequence starts 0,1,3,2,6,7,5,4 with exactly one bit changing per cycle.
  - done at cycle 17; truth_table = 16'hA000 for the a&b&d candidate.
